// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer engine: FSM states, address-type and
// data-width codes, and the helper that turns a width code into a byte step.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_DONE    = 3'd4
    } dma_state_t;

    localparam logic ADDR_FIXED = 1'b0;
    localparam logic ADDR_INCR  = 1'b1;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    // Byte step for one beat; code 3 is treated the same as a word.
    function automatic logic [2:0] step_from_width(input logic [1:0] i_width);
        logic [2:0] w_step;
        case (i_width)
            W_BYTE:  w_step = 3'd1;
            W_HALF:  w_step = 3'd2;
            default: w_step = 3'd4;
        endcase
        return w_step;
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Holds one bus address for the transfer engine: loaded at the start of a
// transfer, advanced after each completed beat. Used for both source and
// destination.
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic                  i_load_type,
    input  logic [1:0]            i_load_width,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ADDR_WIDTH-1:0] o_next_addr
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_type;
    logic [1:0]            r_width;
    logic [ADDR_WIDTH-1:0] w_step;

    // Step is zero for a fixed address, otherwise the beat size in bytes.
    always_comb begin
        w_step = '0;
        if (r_type == ADDR_INCR) begin
            w_step = ADDR_WIDTH'(step_from_width(r_width));
        end
    end

    // The addition simply wraps at the top of the address space.
    assign o_next_addr = r_addr + w_step;
    assign o_addr      = r_addr;

    // Latch the start address and mode on load, step after each beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_type  <= ADDR_FIXED;
            r_width <= W_BYTE;
        end else if (i_load) begin
            r_addr  <= i_load_addr;
            r_type  <= i_load_type;
            r_width <= i_load_width;
        end else if (i_advance) begin
            r_addr  <= o_next_addr;
        end
    end

endmodule

// File: rtl/dma_xfer_fsm.sv
// DMA transfer engine: after a software or hardware start it copies
// i_total_trans beats, each a bus read from the source followed by a bus
// write to the destination, then pulses o_trig_end_fsm to the register file.
module dma_xfer_fsm
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_sw_en,
    input  logic [7:0]            i_hw_en,
    input  logic [7:0]            i_hw_trig,
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [ADDR_WIDTH-1:0] i_dist_addr,
    input  logic [DATA_WIDTH-1:0] i_src_addr_type,
    input  logic [DATA_WIDTH-1:0] i_dist_addr_type,
    input  logic [DATA_WIDTH-1:0] i_src_data_width,
    input  logic [DATA_WIDTH-1:0] i_dist_data_width,
    input  logic [CNT_WIDTH-1:0]  i_total_trans,
    output logic                  o_m_valid,
    output logic                  o_m_rd0_wr1,
    output logic [ADDR_WIDTH-1:0] o_m_addr,
    output logic [DATA_WIDTH-1:0] o_m_wdata,
    input  logic                  i_m_ready,
    input  logic                  i_m_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_m_rd_data,
    output logic                  o_trig_end_fsm,
    output logic                  o_busy
);

    dma_state_t            r_state;
    logic [CNT_WIDTH-1:0]  r_remaining;

    logic                  w_start;
    logic                  w_load;
    logic                  w_wr_accept;
    logic [ADDR_WIDTH-1:0] w_src_next;
    logic [ADDR_WIDTH-1:0] w_dist_addr;
    logic [ADDR_WIDTH-1:0] w_unused_src_addr;
    logic [ADDR_WIDTH-1:0] w_unused_dist_next;
    logic                  w_unused_cfg;

    // Only bit 0 of the type words and bits [1:0] of the width words carry meaning.
    assign w_unused_cfg = ^{i_src_addr_type[DATA_WIDTH-1:1], i_dist_addr_type[DATA_WIDTH-1:1],
                            i_src_data_width[DATA_WIDTH-1:2], i_dist_data_width[DATA_WIDTH-1:2]};

    assign w_start     = i_sw_en | (|(i_hw_en & i_hw_trig));
    assign w_load      = (r_state == ST_IDLE) && w_start;
    assign w_wr_accept = (r_state == ST_WR_REQ) && i_m_ready;

    dma_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_src_addr (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_load_addr  (i_src_addr),
        .i_load_type  (i_src_addr_type[0]),
        .i_load_width (i_src_data_width[1:0]),
        .i_advance    (w_wr_accept),
        .o_addr       (w_unused_src_addr),
        .o_next_addr  (w_src_next)
    );

    dma_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_dist_addr (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_load_addr  (i_dist_addr),
        .i_load_type  (i_dist_addr_type[0]),
        .i_load_width (i_dist_data_width[1:0]),
        .i_advance    (w_wr_accept),
        .o_addr       (w_dist_addr),
        .o_next_addr  (w_unused_dist_next)
    );

    // Transfer FSM with registered bus outputs; o_m_wdata doubles as the one-word data buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_remaining    <= '0;
            o_m_valid      <= 1'b0;
            o_m_rd0_wr1    <= 1'b0;
            o_m_addr       <= '0;
            o_m_wdata      <= '0;
            o_trig_end_fsm <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            o_trig_end_fsm <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_remaining <= i_total_trans;
                        o_busy      <= 1'b1;
                        if (i_total_trans == '0) begin
                            r_state        <= ST_DONE;
                            o_trig_end_fsm <= 1'b1;
                        end else begin
                            r_state     <= ST_RD_REQ;
                            o_m_valid   <= 1'b1;
                            o_m_rd0_wr1 <= 1'b0;
                            o_m_addr    <= i_src_addr;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (i_m_ready) begin
                        if (i_m_rd_valid) begin
                            o_m_wdata   <= i_m_rd_data;
                            o_m_rd0_wr1 <= 1'b1;
                            o_m_addr    <= w_dist_addr;
                            r_state     <= ST_WR_REQ;
                        end else begin
                            o_m_valid   <= 1'b0;
                            r_state     <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (i_m_rd_valid) begin
                        o_m_wdata   <= i_m_rd_data;
                        o_m_valid   <= 1'b1;
                        o_m_rd0_wr1 <= 1'b1;
                        o_m_addr    <= w_dist_addr;
                        r_state     <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (i_m_ready) begin
                        r_remaining <= r_remaining - CNT_WIDTH'(1);
                        o_m_rd0_wr1 <= 1'b0;
                        if (r_remaining == CNT_WIDTH'(1)) begin
                            o_m_valid      <= 1'b0;
                            o_trig_end_fsm <= 1'b1;
                            r_state        <= ST_DONE;
                        end else begin
                            o_m_addr <= w_src_next;
                            r_state  <= ST_RD_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    o_m_valid <= 1'b0;
                    o_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_xfer_fsm.sv
// Directed testbench for dma_xfer_fsm: a bus slave process serves requests and
// checks them against a queue of expected beats filled when each transfer is
// configured.
module tb_dma_xfer_fsm;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        i_sw_en;
    logic [7:0]  i_hw_en;
    logic [7:0]  i_hw_trig;
    logic [31:0] i_src_addr;
    logic [31:0] i_dist_addr;
    logic [31:0] i_src_addr_type;
    logic [31:0] i_dist_addr_type;
    logic [31:0] i_src_data_width;
    logic [31:0] i_dist_data_width;
    logic [31:0] i_total_trans;
    logic        o_m_valid;
    logic        o_m_rd0_wr1;
    logic [31:0] o_m_addr;
    logic [31:0] o_m_wdata;
    logic        i_m_ready;
    logic        i_m_rd_valid;
    logic [31:0] i_m_rd_data;
    logic        o_trig_end_fsm;
    logic        o_busy;

    beat_t sb[$];
    int    compareCount = 0;
    int    failCount    = 0;
    int    endCount     = 0;
    int    busyCount    = 0;
    int    validCount   = 0;
    int    slaveWait    = 0;
    bit    slaveRdSame  = 1'b0;
    int    slaveReadIdx = 0;

    dma_xfer_fsm #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_sw_en           (i_sw_en),
        .i_hw_en           (i_hw_en),
        .i_hw_trig         (i_hw_trig),
        .i_src_addr        (i_src_addr),
        .i_dist_addr       (i_dist_addr),
        .i_src_addr_type   (i_src_addr_type),
        .i_dist_addr_type  (i_dist_addr_type),
        .i_src_data_width  (i_src_data_width),
        .i_dist_data_width (i_dist_data_width),
        .i_total_trans     (i_total_trans),
        .o_m_valid         (o_m_valid),
        .o_m_rd0_wr1       (o_m_rd0_wr1),
        .o_m_addr          (o_m_addr),
        .o_m_wdata         (o_m_wdata),
        .i_m_ready         (i_m_ready),
        .i_m_rd_valid      (i_m_rd_valid),
        .i_m_rd_data       (i_m_rd_data),
        .o_trig_end_fsm    (o_trig_end_fsm),
        .o_busy            (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data the slave returns: address-tagged plus the read index within the transfer.
    function automatic logic [31:0] makeData(input logic [31:0] addr, input int idx);
        return {addr[15:0] ^ 16'hA55A, idx[15:0]};
    endfunction

    function automatic logic [31:0] stepOf(input logic [31:0] addrType, input logic [31:0] width);
        if (addrType[0] == 1'b0) return 32'd0;
        if (width[1:0] == 2'd0) return 32'd1;
        if (width[1:0] == 2'd1) return 32'd2;
        return 32'd4;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Counters sampled just after each rising edge, away from the main process's negedge reads.
    always @(posedge clk) begin
        #1;
        if (o_trig_end_fsm) endCount++;
        if (o_busy) busyCount++;
        if (o_m_valid) validCount++;
    end

    // Bus slave: optional wait states, read data one cycle after ready (or with it), checks every accepted beat.
    initial begin : slaveProc
        int          waitCnt;
        bit          pendingRead;
        logic [31:0] pendingData;
        logic [31:0] holdAddr;
        logic [31:0] holdData;
        logic        holdWr;
        beat_t       expBeat;
        waitCnt      = 0;
        pendingRead  = 1'b0;
        pendingData  = '0;
        holdAddr     = '0;
        holdData     = '0;
        holdWr       = 1'b0;
        i_m_ready    = 1'b0;
        i_m_rd_valid = 1'b0;
        i_m_rd_data  = '0;
        forever begin
            @(negedge clk);
            i_m_ready    = 1'b0;
            i_m_rd_valid = 1'b0;
            if (!rst) begin
                waitCnt     = 0;
                pendingRead = 1'b0;
            end else if (pendingRead) begin
                i_m_rd_valid = 1'b1;
                i_m_rd_data  = pendingData;
                pendingRead  = 1'b0;
            end else if (o_m_valid || waitCnt != 0) begin
                if (waitCnt == 0) begin
                    holdAddr = o_m_addr;
                    holdData = o_m_wdata;
                    holdWr   = o_m_rd0_wr1;
                end else begin
                    checkOutput("holdValid", 32'(o_m_valid), 32'd1);
                    checkOutput("holdAddr", o_m_addr, holdAddr);
                    checkOutput("holdWdata", o_m_wdata, holdData);
                    checkOutput("holdDir", 32'(o_m_rd0_wr1), 32'(holdWr));
                end
                if (waitCnt < slaveWait) begin
                    waitCnt++;
                end else begin
                    waitCnt   = 0;
                    i_m_ready = 1'b1;
                    checkOutput("sbHasEntry", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        expBeat = sb.pop_front();
                        checkOutput("beatDir", 32'(o_m_rd0_wr1), 32'(expBeat.wr));
                        checkOutput("beatAddr", o_m_addr, expBeat.addr);
                        if (expBeat.wr) checkOutput("beatWdata", o_m_wdata, expBeat.data);
                    end
                    if (!o_m_rd0_wr1) begin
                        pendingData = makeData(o_m_addr, slaveReadIdx);
                        slaveReadIdx++;
                        if (slaveRdSame) begin
                            i_m_rd_valid = 1'b1;
                            i_m_rd_data  = pendingData;
                        end else begin
                            pendingRead = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Configure a transfer, queue its expected beats, and pulse the chosen start source.
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] srcType, input logic [31:0] srcW,
                                 input logic [31:0] dst, input logic [31:0] dstType, input logic [31:0] dstW,
                                 input logic [31:0] total, input bit useHw);
        logic [31:0] s;
        logic [31:0] d;
        beat_t       b;
        @(negedge clk);
        i_src_addr        = src;
        i_src_addr_type   = srcType;
        i_src_data_width  = srcW;
        i_dist_addr       = dst;
        i_dist_addr_type  = dstType;
        i_dist_data_width = dstW;
        i_total_trans     = total;
        endCount     = 0;
        busyCount    = 0;
        validCount   = 0;
        slaveReadIdx = 0;
        s = src;
        d = dst;
        for (int k = 0; k < int'(total); k++) begin
            b.wr = 1'b0; b.addr = s; b.data = '0;
            sb.push_back(b);
            b.wr = 1'b1; b.addr = d; b.data = makeData(s, k);
            sb.push_back(b);
            s = s + stepOf(srcType, srcW);
            d = d + stepOf(dstType, dstW);
        end
        if (useHw) begin
            i_hw_en   = 8'h04;
            i_hw_trig = 8'h04;
        end else begin
            i_sw_en = 1'b1;
        end
        @(negedge clk);
        i_sw_en   = 1'b0;
        i_hw_trig = 8'h00;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (endCount == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_timeout"}, 32'(n >= 400), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput({tag, "_endCount"}, 32'(endCount), 32'd1);
        checkOutput({tag, "_sbEmpty"}, 32'(sb.size()), 32'd0);
        checkOutput({tag, "_busyIdle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin : mainSeq
        int n;
        rst               = 1'b0;
        i_sw_en           = 1'b0;
        i_hw_en           = 8'h00;
        i_hw_trig         = 8'h00;
        i_src_addr        = '0;
        i_dist_addr       = '0;
        i_src_addr_type   = '0;
        i_dist_addr_type  = '0;
        i_src_data_width  = '0;
        i_dist_data_width = '0;
        i_total_trans     = '0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rstValid", 32'(o_m_valid), 32'd0);
        checkOutput("rstDir", 32'(o_m_rd0_wr1), 32'd0);
        checkOutput("rstAddr", o_m_addr, 32'd0);
        checkOutput("rstWdata", o_m_wdata, 32'd0);
        checkOutput("rstEnd", 32'(o_trig_end_fsm), 32'd0);
        checkOutput("rstBusy", 32'(o_busy), 32'd0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Four word beats, both addresses incrementing
        $display("[TB] four-beat word copy");
        applyStimulus(32'h1000, 32'd1, 32'd2, 32'h2000, 32'd1, 32'd2, 32'd4, 1'b0);
        checkOutput("t1FirstValid", 32'(o_m_valid), 32'd1);
        checkOutput("t1FirstAddr", o_m_addr, 32'h1000);
        waitDone("t1");

        // Zero-length transfer
        $display("[TB] zero-length transfer");
        applyStimulus(32'h1000, 32'd1, 32'd2, 32'h2000, 32'd1, 32'd2, 32'd0, 1'b0);
        checkOutput("t2EndPulse", 32'(o_trig_end_fsm), 32'd1);
        checkOutput("t2BusyDone", 32'(o_busy), 32'd1);
        @(negedge clk);
        checkOutput("t2EndOneCycle", 32'(o_trig_end_fsm), 32'd0);
        waitDone("t2");
        checkOutput("t2NoValid", 32'(validCount), 32'd0);
        checkOutput("t2BusyCycles", 32'(busyCount), 32'd1);

        // Fixed byte source, incrementing half destination, read data returned with ready
        $display("[TB] fixed byte source / incrementing half destination");
        slaveRdSame = 1'b1;
        applyStimulus(32'h40, 32'd0, 32'd0, 32'h80, 32'd1, 32'd1, 32'd3, 1'b0);
        waitDone("t3");
        slaveRdSame = 1'b0;

        // Slow slave: five wait cycles on every request
        $display("[TB] slave with wait states");
        slaveWait = 5;
        applyStimulus(32'h3000, 32'd1, 32'd2, 32'h4000, 32'd1, 32'd3, 32'd2, 1'b0);
        waitDone("t4");
        slaveWait = 0;

        // Hardware trigger on an enabled line
        $display("[TB] hardware trigger");
        applyStimulus(32'h5000, 32'd1, 32'd2, 32'h5800, 32'd1, 32'd2, 32'd1, 1'b1);
        waitDone("t5");

        // Trigger on a line that is not enabled must not start anything
        @(negedge clk);
        i_hw_en    = 8'h04;
        i_hw_trig  = 8'h08;
        busyCount  = 0;
        validCount = 0;
        repeat (6) @(negedge clk);
        checkOutput("t5NoStartBusy", 32'(busyCount), 32'd0);
        checkOutput("t5NoStartValid", 32'(validCount), 32'd0);
        i_hw_trig = 8'h00;
        i_hw_en   = 8'h00;

        // Reset during the second write of a four-beat transfer
        $display("[TB] reset mid-transfer");
        slaveWait = 3;
        applyStimulus(32'h6000, 32'd1, 32'd2, 32'h7000, 32'd1, 32'd2, 32'd4, 1'b0);
        n = 0;
        while (!(o_m_valid && o_m_rd0_wr1 && o_m_addr == 32'h7004) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6ReachBeat2", 32'(n >= 200), 32'd0);
        #2 rst = 1'b0;
        #1;
        checkOutput("t6RstValid", 32'(o_m_valid), 32'd0);
        checkOutput("t6RstDir", 32'(o_m_rd0_wr1), 32'd0);
        checkOutput("t6RstAddr", o_m_addr, 32'd0);
        checkOutput("t6RstWdata", o_m_wdata, 32'd0);
        checkOutput("t6RstBusy", 32'(o_busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t6NoEndPulse", 32'(endCount), 32'd0);
        sb.delete();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t6IdleAfterRst", 32'(o_busy), 32'd0);
        applyStimulus(32'h6000, 32'd1, 32'd2, 32'h7000, 32'd1, 32'd2, 32'd4, 1'b0);
        waitDone("t6");
        slaveWait = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/dma_xfer_fsm.md
Name: dma_xfer_fsm

Overview:
- Transfer engine directly downstream of the DMA register file.
- Consumes the decoded channel configuration (addresses, address types, data widths, transfer count, sw/hw enables) and moves data one beat at a time: bus read from source, then bus write to destination.
- On completion, pulses o_trig_end_fsm back to the register file, which sets the interrupt status and clears sw_en.

Parameters:
DATA_WIDTH, 32, bus data width
ADDR_WIDTH, 32, bus address width
CNT_WIDTH, 32, width of the transfer counter and total-transfer input

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
i_sw_en  in  1  software start, level, from register file
i_hw_en  in  8  per-line hardware trigger enables
i_hw_trig  in  8  hardware trigger request lines
i_src_addr  in  ADDR_WIDTH  source start address
i_dist_addr  in  ADDR_WIDTH  destination start address
i_src_addr_type  in  DATA_WIDTH  bit0: 0 = fixed, 1 = incrementing
i_dist_addr_type  in  DATA_WIDTH  bit0: 0 = fixed, 1 = incrementing
i_src_data_width  in  DATA_WIDTH  bits[1:0]: 0 = byte, 1 = half, 2/3 = word
i_dist_data_width  in  DATA_WIDTH  same encoding as source
i_total_trans  in  CNT_WIDTH  number of beats
o_m_valid  out  1  bus master request valid
o_m_rd0_wr1  out  1  0 = read, 1 = write
o_m_addr  out  ADDR_WIDTH  bus address
o_m_wdata  out  DATA_WIDTH  write data
i_m_ready  in  1  slave accepts the request this cycle
i_m_rd_valid  in  1  read data valid
i_m_rd_data  in  DATA_WIDTH  read data
o_trig_end_fsm  out  1  one-cycle completion pulse
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst low): state IDLE; o_m_valid, o_m_rd0_wr1, o_trig_end_fsm, o_busy = 0; o_m_addr, o_m_wdata, internal counters and data buffer = 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE. All outputs are registered.
- IDLE:
  - Start condition: i_sw_en OR |(i_hw_en & i_hw_trig); sw has priority, both start identically.
  - On start, latch all config inputs into working registers; later config changes are ignored until the next start.
  - If latched total == 0: go to DONE, no bus traffic. Otherwise go to RD_REQ.
- RD_REQ:
  - o_m_valid = 1, o_m_rd0_wr1 = 0, o_m_addr = current src address.
  - Hold all of these stable until i_m_ready.
  - On i_m_ready: drop o_m_valid next cycle; go to RD_WAIT.
  - If i_m_rd_valid arrives in the same cycle as i_m_ready, capture the data and go directly to WR_REQ.
- RD_WAIT: wait any number of cycles for i_m_rd_valid; capture i_m_rd_data into the one-word buffer; go to WR_REQ.
- WR_REQ:
  - o_m_valid = 1, o_m_rd0_wr1 = 1, o_m_addr = current dist address, o_m_wdata = buffer.
  - Hold stable until i_m_ready.
  - On acceptance: decrement remaining count, advance addresses.
  - If remaining becomes 0, go to DONE; else go to RD_REQ.
- Address advance: after each completed beat, address += (1 << width) when type bit0 = 1, unchanged when bit0 = 0. Width 3 is treated as word (step 4). Addition wraps modulo 2^ADDR_WIDTH with no error.
- Width mismatch: data passes through unmodified; byte-lane selection is the slave's responsibility.
- DONE: o_trig_end_fsm = 1 for exactly one cycle, then IDLE. i_sw_en is cleared by the register file at that edge, so there is no retrigger. A still-asserted hw trigger in IDLE starts a new transfer.
- Minimum beat latency with zero-wait slave: 3 cycles (RD_REQ, WR_REQ, plus the RD_WAIT cycle when read data arrives one cycle after ready).
- Reset mid-transfer: immediate return to IDLE with reset values; no end pulse.
- i_sw_en dropping mid-transfer has no effect; there is no abort input.

Decomposition:
- Shared package dma_pkg: state encoding, address-type constants (ADDR_FIXED = 0, ADDR_INCR = 1), width codes (W_BYTE = 0, W_HALF = 1, W_WORD = 2), and a function returning the step size from a width code.
- One sub-module, dma_addr_gen: holds, loads and advances a single address. Instantiated twice, for source and destination.

Test Plan:
- Zero-wait slave; sw_en = 1, src = 0x1000 incr word, dist = 0x2000 incr word, total = 4 -> reads at 0x1000/1004/1008/100C, writes at 0x2000/2004/2008/200C with matching data; exactly one o_trig_end_fsm pulse.
- total = 0, sw_en = 1 -> no o_m_valid at all; end pulse 1 cycle after leaving IDLE; o_busy high for exactly one cycle (DONE).
- src fixed byte at 0x40, dist incr half at 0x80, total = 3 -> reads all at 0x40; writes at 0x80/0x82/0x84.
- Slave holds i_m_ready low for 5 cycles on each request -> o_m_addr, o_m_valid and o_m_wdata stay stable; no beat is lost or duplicated.
- hw_en = 0x04, hw_trig = 0x04 with sw_en = 0 -> transfer starts; hw_trig = 0x08 with hw_en = 0x04 -> no start.
- rst asserted during WR_REQ of beat 2 of 4 -> all outputs return to reset values asynchronously, no end pulse; a fresh start afterwards restarts from the latched start addresses.
